// File: rtl/output_wrapper_if.sv
// Result-in / word-out bundle for output_wrapper; master is the wrapper side,
// slave is the core/downstream environment side.
interface output_wrapper_if #(
  parameter int DATA_W = 32
);
  logic                  resValid;
  logic [2*DATA_W-1:0]   resIn;
  logic                  oBufferReady;
  logic [DATA_W-1:0]     outBus;
  logic                  outValid;
  logic                  outAccept;
  logic                  overflow;
  logic                  busy;

  modport master (
    input  resValid, resIn, outAccept,
    output oBufferReady, outBus, outValid, overflow, busy
  );

  modport slave (
    output resValid, resIn, outAccept,
    input  oBufferReady, outBus, outValid, overflow, busy
  );
endinterface

// File: rtl/output_wrapper.sv
// Buffers double-width core results and serialises each as lo then hi word.
// First word is valid one cycle after capture into an empty buffer; words hold under !outAccept.
module output_wrapper #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  output_wrapper_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND_LO = 2'd1;
  localparam logic [1:0] SEND_HI = 2'd2;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   out_bus_q, out_bus_d;
  logic                out_valid_q, out_valid_d;
  logic                overflow_q, overflow_d;
  logic                wr_en;
  logic                pop;
  logic [2*DATA_W-1:0] next_entry;

  assign wr_en = bus.resValid && (count_q < FULL);
  assign pop   = (state_q == SEND_HI) && bus.outAccept;

  // A result captured on the same edge it becomes head is not in the array yet.
  assign next_entry = (wr_en && (count_q == CNT_W'(1))) ? bus.resIn
                                                        : mem_q[rd_ptr_q + PTR_W'(1)];

  always_comb begin
    state_d     = state_q;
    out_bus_d   = out_bus_q;
    out_valid_d = out_valid_q;
    wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    overflow_d  = overflow_q | (bus.resValid & ~wr_en);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = SEND_LO;
          out_valid_d = 1'b1;
          out_bus_d   = mem_q[rd_ptr_q][DATA_W-1:0];
        end
      end
      SEND_LO: begin
        if (bus.outAccept) begin
          state_d   = SEND_HI;
          out_bus_d = mem_q[rd_ptr_q][2*DATA_W-1:DATA_W];
        end
      end
      SEND_HI: begin
        if (bus.outAccept) begin
          if (count_d != '0) begin
            state_d   = SEND_LO;
            out_bus_d = next_entry[DATA_W-1:0];
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_bus_d   = '0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_bus_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.resIn;
    end
  end

  assign bus.oBufferReady = (count_q < FULL);
  assign bus.outBus       = out_bus_q;
  assign bus.outValid     = out_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_output_wrapper.sv
// Bench for output_wrapper: directed scenarios plus random traffic against a queue-based result model.
module tb_output_wrapper;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  output_wrapper_if #(.DATA_W(DATA_W)) bus ();

  output_wrapper #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored results in arrival order, half of head already sent.
  logic [63:0] res_q[$];
  int          cnt;
  bit          half;
  bit          exp_valid;
  bit          ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    res_q.delete();
    cnt       = 0;
    half      = 1'b0;
    exp_valid = 1'b0;
    ovf       = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("ready",    bus.oBufferReady, cnt < DEPTH);
    check_eq("overflow", bus.overflow,     ovf);
    check_eq("busy",     bus.busy,         cnt > 0);
    check_eq("valid",    bus.outValid,     exp_valid);
    if (exp_valid)
      check_eq("data", bus.outBus, half ? res_q[0][63:32] : res_q[0][31:0]);
  endtask

  // One clock: check what is presented, drive inputs, advance the model across the edge.
  task automatic step(input bit rv, input logic [63:0] d, input bit acc);
    int cnt_before;
    bit wr, pop;
    @(negedge clk);
    check_outputs();
    bus.resValid  = rv;
    bus.resIn     = d;
    bus.outAccept = acc;
    cnt_before = cnt;
    wr  = rv && (cnt_before < DEPTH);
    pop = 1'b0;
    if (rv && !wr) ovf = 1'b1;
    if (exp_valid && acc) begin
      if (half) begin
        pop  = 1'b1;
        half = 1'b0;
      end else begin
        half = 1'b1;
      end
    end
    if (pop) void'(res_q.pop_front());
    if (wr)  res_q.push_back(d);
    cnt = cnt_before + int'(wr) - int'(pop);
    exp_valid = (cnt > 0) && (exp_valid || cnt_before > 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_valid",    bus.outValid,     1'b0);
    check_eq("rst_bus",      bus.outBus,       '0);
    check_eq("rst_overflow", bus.overflow,     1'b0);
    check_eq("rst_ready",    bus.oBufferReady, 1'b1);
    check_eq("rst_busy",     bus.busy,         1'b0);
    bus.resValid  = 1'b0;
    bus.resIn     = '0;
    bus.outAccept = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.resValid  = 1'b0;
    bus.resIn     = '0;
    bus.outAccept = 1'b0;
    model_clear();
    #12;
    check_eq("por_valid", bus.outValid,     1'b0);
    check_eq("por_bus",   bus.outBus,       '0);
    check_eq("por_ready", bus.oBufferReady, 1'b1);
    check_eq("por_busy",  bus.busy,         1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single result with outAccept held high.
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Backpressure: lo word must hold for several cycles.
    step(1'b1, 64'hCAFE_0001_BEEF_0002, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Fill, overflow, drain.
    do_reset();
    step(1'b1, 64'hA, 1'b0);
    step(1'b1, 64'hB, 1'b0);
    step(1'b1, 64'hC, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);

    // Write colliding with a pop while full is dropped.
    do_reset();
    step(1'b1, 64'h1111_1111_2222_2222, 1'b0);
    step(1'b1, 64'h3333_3333_4444_4444, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 64'h5555_5555_6666_6666, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Write colliding with a pop while not full streams with no gap.
    do_reset();
    step(1'b1, 64'h7777_7777_8888_8888, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 64'h9999_9999_AAAA_AAAA, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Reset during SEND_HI with two results stored, then stay idle.
    do_reset();
    step(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(($urandom % 3) == 0, {$urandom, $urandom}, ($urandom % 4) != 0);
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    @(negedge clk);
    check_outputs();
    check_eq("drained_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
